// File: rtl/vga_sync_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : vga_sync_decoder
// Description : VGA sink-side timing recovery. Locks to the sync stream, recovers
//               x/y/de, flags timing errors and captures one probe pixel per arm.
//               Optional FRAME_SUM_EN adds a per-frame 16-bit pixel checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    input  logic        arm,
    input  logic        clr_err,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        err_h,
    output logic        err_v,
    output logic [11:0] cap_rgb,
    output logic        cap_valid
`ifdef FRAME_SUM_EN
    ,
    output logic [15:0] frame_sum
`endif
);

    localparam int H_START = H_SYNC + H_BACK;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int V_END   = V_START + V_ACTIVE;
    // h_cnt saturates at 1023, so the missing-hsync threshold is clamped to it
    localparam int TIMEOUT = (2 * H_TOTAL > 1023) ? 1023 : 2 * H_TOTAL;
    localparam int CW      = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  clean_cnt;
    logic [CW-1:0]  clean_nxt;
    logic           set_err_h;
    logic           set_err_v;

    logic           hs_s1, hs_s2;
    logic           vs_s1, vs_s2;
    logic [11:0]    rgb_s1, rgb_s2;
    logic           h_fall;
    logic           v_fall;
    logic [9:0]     h_cnt;
    logic [9:0]     v_cnt;
    logic           line_ok;
    logic           frame_ok;
    logic           timeout;
    logic           win;
    logic           armed;

    assign h_fall   = hs_s2 & ~hs_s1;
    assign v_fall   = vs_s2 & ~vs_s1;
    assign line_ok  = ({1'b0, h_cnt} + 11'd1) == 11'(H_TOTAL);
    assign frame_ok = ({1'b0, v_cnt} + 11'd1) == 11'(V_TOTAL);
    assign timeout  = h_cnt >= 10'(TIMEOUT);
    assign locked   = (state == LOCKED);

    assign win = locked
               && (h_cnt >= 10'(H_START)) && (h_cnt < 10'(H_END))
               && (v_cnt >= 10'(V_START)) && (v_cnt < 10'(V_END));

    always_comb begin
        state_nxt = state;
        clean_nxt = clean_cnt;
        set_err_h = 1'b0;
        set_err_v = 1'b0;
        case (state)
            SEARCH: begin
                if (v_fall && !timeout) begin
                    state_nxt = ACQUIRE;
                    clean_nxt = '0;
                end
            end
            ACQUIRE: begin
                if (timeout || (h_fall && !line_ok) || (v_fall && !frame_ok)) begin
                    state_nxt = SEARCH;
                end else if (v_fall) begin
                    if (int'(clean_cnt) + 1 == LOCK_FRAMES) begin
                        state_nxt = LOCKED;
                    end else begin
                        clean_nxt = clean_cnt + 1'b1;
                    end
                end
            end
            LOCKED: begin
                set_err_h = timeout || (h_fall && !line_ok);
                set_err_v = v_fall && !frame_ok;
                if (set_err_h || set_err_v) begin
                    state_nxt = SEARCH;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            clean_cnt <= '0;
            err_h     <= 1'b0;
            err_v     <= 1'b0;
        end else begin
            state     <= state_nxt;
            clean_cnt <= clean_nxt;
            // a new error outranks a coincident clear
            err_h     <= set_err_h | (err_h & ~clr_err);
            err_v     <= set_err_v | (err_v & ~clr_err);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_s1  <= 1'b0;
            hs_s2  <= 1'b0;
            vs_s1  <= 1'b0;
            vs_s2  <= 1'b0;
            rgb_s1 <= '0;
            rgb_s2 <= '0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            hs_s1  <= hsync;
            hs_s2  <= hs_s1;
            vs_s1  <= vsync;
            vs_s2  <= vs_s1;
            rgb_s1 <= rgb;
            rgb_s2 <= rgb_s1;
            if (h_fall) begin
                h_cnt <= '0;
            end else if (h_cnt != 10'h3FF) begin
                h_cnt <= h_cnt + 10'd1;
            end
            if (v_fall) begin
                v_cnt <= '0;
            end else if (h_fall && (v_cnt != 10'h3FF)) begin
                v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    // rgb_s2 is aligned with h_cnt/v_cnt, so this stage lands two clocks after sampling
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            de          <= win;
            x           <= win ? (h_cnt - 10'(H_START)) : '0;
            y           <= win ? (v_cnt - 10'(V_START)) : '0;
            pix_rgb     <= win ? rgb_s2 : '0;
            frame_start <= v_fall;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed     <= 1'b0;
            cap_rgb   <= '0;
            cap_valid <= 1'b0;
        end else if (arm) begin
            armed     <= 1'b1;
            cap_valid <= 1'b0;
        end else if (armed && de && (x == probe_x) && (y == probe_y)) begin
            armed     <= 1'b0;
            cap_rgb   <= pix_rgb;
            cap_valid <= 1'b1;
        end
    end

`ifdef FRAME_SUM_EN
    logic [15:0] sum_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else if (frame_start) begin
            frame_sum <= sum_acc;
            sum_acc   <= '0;
        end else if (de) begin
            sum_acc   <= sum_acc + {4'b0000, pix_rgb};
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_sync_decoder
// Description : Randomized self-checking bench for vga_sync_decoder on a reduced raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_decoder;

    localparam int HS = 4, HB = 3, HA = 16, HT = 28;
    localparam int VS = 2, VB = 3, VA = 10, VT = 18;
    localparam int LF = 2;
    localparam int TO = (2 * HT > 1023) ? 1023 : 2 * HT;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync, vsync, arm, clr_err;
    logic [11:0] rgb;
    logic [9:0]  probe_x, probe_y;
    logic [9:0]  x, y;
    logic        de, frame_start, locked, err_h, err_v, cap_valid;
    logic [11:0] pix_rgb, cap_rgb;
`ifdef FRAME_SUM_EN
    logic [15:0] frame_sum;
`endif
    logic [49:0] all_outs;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .probe_x(probe_x), .probe_y(probe_y), .arm(arm), .clr_err(clr_err),
        .x(x), .y(y), .de(de), .pix_rgb(pix_rgb), .frame_start(frame_start),
        .locked(locked), .err_h(err_h), .err_v(err_v), .cap_rgb(cap_rgb),
`ifdef FRAME_SUM_EN
        .frame_sum(frame_sum),
`endif
        .cap_valid(cap_valid)
    );

    assign all_outs = {x, y, de, pix_rgb, frame_start, locked, err_h, err_v, cap_rgb, cap_valid};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (integer raster position + lock mode) ----------------
    bit          d1h, d1v, d2h, d2v;
    logic [11:0] d1rgb, m_rgb, m_pix, m_cap;
    int          pos, line, mode, clean, m_x, m_y;
    bit          m_de, m_fs, m_err_h, m_err_v, m_cap_valid, m_armed;
    int          m_acc, m_sum;

    task automatic model_clear();
        d1h = 0; d1v = 0; d2h = 0; d2v = 0; d1rgb = '0; m_rgb = '0; m_pix = '0; m_cap = '0;
        pos = 0; line = 0; mode = 0; clean = 0; m_x = 0; m_y = 0;
        m_de = 0; m_fs = 0; m_err_h = 0; m_err_v = 0; m_cap_valid = 0; m_armed = 0;
        m_acc = 0; m_sum = 0;
    endtask

    task automatic model_step();
        bit hf, vf, w, stuck, bad_h, bad_v;
        hf = d2h && !d1h;
        vf = d2v && !d1v;
        if (arm) begin
            m_cap_valid = 0; m_armed = 1;
        end else if (m_armed && m_de && m_x == int'(probe_x) && m_y == int'(probe_y)) begin
            m_cap = m_pix; m_cap_valid = 1; m_armed = 0;
        end
        if (m_fs) begin
            m_sum = m_acc; m_acc = 0;
        end else if (m_de) begin
            m_acc = (m_acc + int'(m_pix)) % 65536;
        end
        w = (mode == 2) && pos >= HS + HB && pos < HS + HB + HA
                        && line >= VS + VB && line < VS + VB + VA;
        m_de  = w;
        m_x   = w ? pos - (HS + HB) : 0;
        m_y   = w ? line - (VS + VB) : 0;
        m_pix = w ? m_rgb : 12'h000;
        m_fs  = vf;
        stuck = pos >= TO;
        bad_h = stuck || (hf && pos + 1 != HT);
        bad_v = vf && line + 1 != VT;
        m_err_h = ((mode == 2) && bad_h) || (m_err_h && !clr_err);
        m_err_v = ((mode == 2) && bad_v) || (m_err_v && !clr_err);
        if (mode == 0) begin
            if (vf && !stuck) begin mode = 1; clean = 0; end
        end else if (bad_h || bad_v) begin
            mode = 0;
        end else if (mode == 1 && vf) begin
            clean++;
            if (clean == LF) mode = 2;
        end
        pos  = hf ? 0 : (pos < 1023 ? pos + 1 : 1023);
        line = vf ? 0 : (hf ? (line < 1023 ? line + 1 : 1023) : line);
        m_rgb = d1rgb;
        d2h = d1h; d2v = d1v;
        d1h = hsync; d1v = vsync; d1rgb = rgb;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_clear();
        else        model_step();
    end

    // ---------------- per-cycle comparison and scenario monitors ----------------
    bit mon_en = 0, prev_de = 0, first_lock = 0, frame_full = 0, f00_frame = 0, stall_flag = 0;
    int fs_seen = 0, de_cnt = 0, stall_de = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("video", 64'({x, y, de, pix_rgb}),
                  64'({10'(m_x), 10'(m_y), m_de, m_pix}));
            check("status", 64'({frame_start, locked, err_h, err_v, cap_rgb, cap_valid}),
                  64'({m_fs, mode == 2, m_err_h, m_err_v, m_cap, m_cap_valid}));
`ifdef FRAME_SUM_EN
            check("frame_sum", 64'(frame_sum), 64'(m_sum));
`endif
            if (frame_start) fs_seen++;
            if (locked && !first_lock) begin
                first_lock = 1;
                check("lock_fs_count", 64'(fs_seen), 64'd3);
            end
            if (frame_start) begin
                if (frame_full) check("de_per_frame", 64'(de_cnt), 64'(HA * VA));
                de_cnt = 0;
                frame_full = locked;
            end else if (!locked) begin
                frame_full = 0;
            end
            if (de) de_cnt++;
            if (de && !prev_de) begin
                check("line_start_x", 64'(x), 64'd0);
                if (f00_frame && y == 10'd0) check("first_px_rgb", 64'(pix_rgb), 64'h000F00);
            end
            if (stall_flag && de) stall_de++;
            prev_de = de;
        end
    end

    // ---------------- stimulus ----------------
    int cyc = 0, arm_at = -10, clr_at = -10, drop_at = -10;
    bit xy_mode = 0, const_mode = 0, rand_mode = 0;

    task automatic drive(input bit h, input bit v, input int p, input int l);
        int ax, ay;
        ax = p - (HS + HB);
        ay = l - (VS + VB);
        @(negedge clk);
        hsync = h;
        vsync = v;
        rgb   = 12'($urandom);
        if (const_mode) rgb = 12'h001;
        if (ax >= 0 && ax < HA && ay >= 0 && ay < VA) begin
            if (xy_mode) rgb = {2'b00, 10'(ax) ^ 10'(ay)};
            if (f00_frame && ax == 0 && ay == 0) rgb = 12'hF00;
        end
        arm     = (cyc == arm_at) || (rand_mode && $urandom_range(0, 199) == 0);
        clr_err = (cyc == clr_at) || (rand_mode && $urandom_range(0, 149) == 0);
        if (cyc == drop_at) check("rearm_drop", 64'(cap_valid), 64'd0);
        cyc++;
    endtask

    task automatic run_line(input int l, input int len);
        for (int p = 0; p < len; p++) drive(p >= HS, l >= VS, p, l);
    endtask

    task automatic frame(input int short_l, input int delta);
        for (int l = 0; l < VT; l++) run_line(l, (l == short_l) ? HT + delta : HT);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("reset_outs", 64'(all_outs), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = '0;
        arm = 1'b0; clr_err = 1'b0; probe_x = '0; probe_y = '0;
        repeat (3) @(negedge clk);
        #1 check("reset_state", 64'(all_outs), 64'd0);
        #1 reset = 1'b1;
        mon_en = 1;

        // ideal stream: lock on the third vsync fall
        repeat (4) frame(-1, 0);
        check("t1_locked", 64'(locked), 64'd1);
        check("t1_errs", 64'({err_h, err_v}), 64'd0);

        // marked first active pixel
        f00_frame = 1;
        frame(-1, 0);
        f00_frame = 0;

        // probe the last active pixel with an x^y pattern, then re-arm
        probe_x = 10'(HA - 1);
        probe_y = 10'(VA - 1);
        xy_mode = 1;
        arm_at  = cyc;
        frame(-1, 0);
        check("t3_cap_valid", 64'(cap_valid), 64'd1);
        check("t3_cap_rgb", 64'(cap_rgb), 64'((HA - 1) ^ (VA - 1)));
        arm_at  = cyc + 2;
        drop_at = cyc + 3;
        frame(-1, 0);
        xy_mode = 0;

        // one short line
        frame(5, -1);
        check("t4_err_h", 64'(err_h), 64'd1);
        check("t4_unlocked", 64'(locked), 64'd0);
        repeat (3) frame(-1, 0);
        check("t4_relocked", 64'(locked), 64'd1);
        clr_at = cyc + 1;
        frame(-1, 0);
        check("t4_cleared", 64'(err_h), 64'd0);

        // hsync stuck high past the timeout
        stall_flag = 1;
        for (int i = 0; i < TO + 10; i++) drive(1'b1, 1'b1, -1, -1);
        stall_flag = 0;
        check("t5_err_h", 64'(err_h), 64'd1);
        check("t5_unlocked", 64'(locked), 64'd0);
        check("t5_stall_de", 64'(stall_de), 64'd0);
        repeat (5) frame(-1, 0);
        check("t5_relocked", 64'(locked), 64'd1);

        // reset in the middle of a frame, constant pixel data
        const_mode = 1;
        for (int l = 0; l < 9; l++) run_line(l, HT);
        pulse_reset();
        for (int l = 9; l < VT; l++) run_line(l, HT);
        repeat (3) frame(-1, 0);
        check("t6_relocked", 64'(locked), 64'd1);
        repeat (2) frame(-1, 0);
`ifdef FRAME_SUM_EN
        check("t6_frame_sum", 64'(frame_sum), 64'(16'(HA * VA)));
`endif
        const_mode = 0;

        // randomized probes, arm/clear pulses and line-length faults
        rand_mode = 1;
        repeat (8) begin
            probe_x = 10'($urandom_range(0, HA + 3));
            probe_y = 10'($urandom_range(0, VA + 3));
            frame(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, VT - 1)) : -1,
                  ($urandom_range(0, 1) == 0) ? 1 : -1);
        end
        rand_mode = 0;
        repeat (2) drive(1'b1, 1'b1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
